audio_frame_sequencer: RTL

Central timing controller for the sound datapath. It replaces the free-running clock dividers with single-cycle enable ticks on the ac97_bitclk domain (12.288 MHz).
- Generates a 512 Hz frame sequencer with an 8-step schedule: length 256 Hz, sweep 128 Hz, envelope 64 Hz.
- Generates exact-average channel frequency ticks through fractional accumulators: 131072 Hz for ch1/ch2 and 65536 Hz for ch3.
- Sits between sound_registers (master enable, restart) and the SquareWave and WaveformPlayer channels, which consume the ticks as clock enables.

---
 rtl/audio_timing_pkg.sv | 20 ++
 rtl/audio_frame_sequencer_frac_tick_gen.sv | 38 +++
 rtl/audio_frame_sequencer.sv | 76 +++++++
 3 files changed

// File: rtl/audio_timing_pkg.sv
// Shared timing constants for the sound datapath: clock rates, default
// fractional-divider ratios and the 8-step frame schedule decode masks.
package audio_timing_pkg;

   localparam int AC97_BITCLK_HZ = 12288000;
   localparam int FRAME_HZ       = 512;
   localparam int FRAME_DIV_DEF  = AC97_BITCLK_HZ / FRAME_HZ;

   // 12.288 MHz * 4/375 = 131072 Hz, 12.288 MHz * 2/375 = 65536 Hz
   localparam int F12_NUM_DEF = 4;
   localparam int F12_DEN_DEF = 375;
   localparam int F3_NUM_DEF  = 2;
   localparam int F3_DEN_DEF  = 375;

   // Bit s is set when step s fires the corresponding enable
   localparam logic [7:0] LEN_STEP_MASK   = 8'b01010101;
   localparam logic [7:0] SWEEP_STEP_MASK = 8'b01000100;
   localparam logic [7:0] ENV_STEP_MASK   = 8'b10000000;

endpackage

// File: rtl/audio_frame_sequencer_frac_tick_gen.sv
// Fractional-rate tick generator: emits exactly NUM single-cycle ticks per
// DEN enabled cycles, spaced floor or ceil of DEN/NUM apart.
module frac_tick_gen #(
   parameter int NUM = 4,
   parameter int DEN = 375
) (
   input  logic ac97_bitclk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int AW = $clog2(DEN);
   localparam logic [AW:0] NUM_W = (AW+1)'(NUM);
   localparam logic [AW:0] DEN_W = (AW+1)'(DEN);

   logic [AW-1:0] acc;
   logic [AW:0]   sum;
   logic [AW:0]   wrapped;

   // One extra bit keeps acc+NUM exact since acc < DEN and NUM < DEN
   assign sum     = {1'b0, acc} + NUM_W;
   assign wrapped = sum - DEN_W;

   always_ff @(posedge ac97_bitclk) begin
      if (reset || !enable) begin
         acc  <= '0;
         tick <= 1'b0;
      end else if (sum >= DEN_W) begin
         acc  <= wrapped[AW-1:0];
         tick <= 1'b1;
      end else begin
         acc  <= sum[AW-1:0];
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/audio_frame_sequencer.sv
// Sound timing controller: 512 Hz frame sequencer with length/sweep/envelope
// schedule plus fractional channel-frequency enable ticks.
module audio_frame_sequencer
   import audio_timing_pkg::*;
#(
   parameter int FRAME_DIV = FRAME_DIV_DEF,
   parameter int F12_NUM   = F12_NUM_DEF,
   parameter int F12_DEN   = F12_DEN_DEF,
   parameter int F3_NUM    = F3_NUM_DEF,
   parameter int F3_DEN    = F3_DEN_DEF
) (
   input  logic       ac97_bitclk,
   input  logic       reset,
   input  logic       master_sound_enable,
   input  logic       seq_restart,
   output logic       frame_tick,
   output logic [2:0] frame_step,
   output logic       length_tick,
   output logic       sweep_tick,
   output logic       env_tick,
   output logic       freq12_tick,
   output logic       freq3_tick
);

   localparam int PW = $clog2(FRAME_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(FRAME_DIV - 1);

   logic [PW-1:0] pre_cnt;

   always_ff @(posedge ac97_bitclk) begin
      if (reset || !master_sound_enable) begin
         pre_cnt     <= '0;
         frame_step  <= 3'd0;
         frame_tick  <= 1'b0;
         length_tick <= 1'b0;
         sweep_tick  <= 1'b0;
         env_tick    <= 1'b0;
      end else if (seq_restart) begin
         // Restart beats a coincident terminal count: no frame tick this edge
         pre_cnt     <= '0;
         frame_step  <= 3'd0;
         frame_tick  <= 1'b0;
         length_tick <= 1'b0;
         sweep_tick  <= 1'b0;
         env_tick    <= 1'b0;
      end else if (pre_cnt == PRE_LAST) begin
         pre_cnt     <= '0;
         frame_step  <= frame_step + 3'd1;
         frame_tick  <= 1'b1;
         length_tick <= LEN_STEP_MASK[frame_step];
         sweep_tick  <= SWEEP_STEP_MASK[frame_step];
         env_tick    <= ENV_STEP_MASK[frame_step];
      end else begin
         pre_cnt     <= pre_cnt + 1'b1;
         frame_tick  <= 1'b0;
         length_tick <= 1'b0;
         sweep_tick  <= 1'b0;
         env_tick    <= 1'b0;
      end
   end

   frac_tick_gen #(.NUM(F12_NUM), .DEN(F12_DEN)) u_freq12 (
      .ac97_bitclk (ac97_bitclk),
      .reset       (reset),
      .enable      (master_sound_enable),
      .tick        (freq12_tick)
   );

   frac_tick_gen #(.NUM(F3_NUM), .DEN(F3_DEN)) u_freq3 (
      .ac97_bitclk (ac97_bitclk),
      .reset       (reset),
      .enable      (master_sound_enable),
      .tick        (freq3_tick)
   );

endmodule
